// File: rtl/cpu_clock_controller.sv
// rtl/cpu_clock_controller.sv - run/step/halt clock-enable controller for the CPU datapath
module cpu_clock_controller #(
    parameter logic [31:0] DIV0      = 32'd24_999_999,
    parameter logic [31:0] DIV1      = 32'd4_999_999,
    parameter logic [31:0] DIV2      = 32'd499_999,
    parameter logic [31:0] DIV3      = 32'd0,
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        run_sw,
    input  logic        step_btn,
    input  logic [1:0]  div_sel,
    input  logic        halt_req,
    output logic        cpu_en,
    output logic        running,
    output logic        cpu_halted,
    output logic [15:0] en_count
);

    // The debounce counter only needs to reach DB_CYCLES-1: the flip happens
    // on the edge that would have completed the window.
    localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    logic            run_meta_q, run_meta_d;
    logic            run_sync_q, run_sync_d;
    logic            step_meta_q, step_meta_d;
    logic            step_sync_q, step_sync_d;
    logic            db_level_q, db_level_d;
    logic            db_prev_q, db_prev_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    state_t          state_q, state_d;
    logic [31:0]     div_cnt_q, div_cnt_d;
    logic            cpu_en_q, cpu_en_d;
    logic            cpu_halted_q, cpu_halted_d;
    logic [15:0]     en_count_q, en_count_d;

    logic            step_evt;
    logic            pulse;
    logic [31:0]     tc;

    // Synchronisers and step-button debounce: level follows the synced input
    // only after it has disagreed for DB_CYCLES consecutive cycles.
    always_comb begin
        run_meta_d  = run_sw;
        run_sync_d  = run_meta_q;
        step_meta_d = step_btn;
        step_sync_d = step_meta_q;
        db_level_d  = db_level_q;
        db_prev_d   = db_level_q;
        db_cnt_d    = '0;
        if (step_sync_q != db_level_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_level_d = step_sync_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    assign step_evt = db_level_q & ~db_prev_q;

    // Terminal count follows div_sel without delay so a rate change acts at once.
    always_comb begin
        tc = DIV3;
        case (div_sel)
            2'd0:    tc = DIV0;
            2'd1:    tc = DIV1;
            2'd2:    tc = DIV2;
            default: tc = DIV3;
        endcase
    end

    // Mode FSM and divider: halt_req beats run_sw=0 beats a divider pulse in RUN.
    always_comb begin
        state_d      = state_q;
        div_cnt_d    = div_cnt_q;
        cpu_halted_d = cpu_halted_q;
        pulse        = 1'b0;
        case (state_q)
            ST_HALT: begin
                if (!run_sync_q) begin
                    cpu_halted_d = 1'b0;
                end
                if (run_sync_q && !cpu_halted_q) begin
                    state_d   = ST_RUN;
                    div_cnt_d = '0;
                end else if (step_evt && !run_sync_q) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_d      = ST_HALT;
                    cpu_halted_d = 1'b1;
                    div_cnt_d    = '0;
                end else if (!run_sync_q) begin
                    state_d   = ST_HALT;
                    div_cnt_d = '0;
                end else if (div_cnt_q >= tc) begin
                    div_cnt_d = '0;
                    pulse     = 1'b1;
                end else begin
                    div_cnt_d = div_cnt_q + 32'd1;
                end
            end
            ST_STEP: begin
                pulse   = 1'b1;
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
        cpu_en_d   = pulse;
        en_count_d = en_count_q + {15'd0, pulse};
    end

    // State registers; reset aborts any run or debounce in progress.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            run_meta_q   <= 1'b0;
            run_sync_q   <= 1'b0;
            step_meta_q  <= 1'b0;
            step_sync_q  <= 1'b0;
            db_level_q   <= 1'b0;
            db_prev_q    <= 1'b0;
            db_cnt_q     <= '0;
            state_q      <= ST_HALT;
            div_cnt_q    <= '0;
            cpu_en_q     <= 1'b0;
            cpu_halted_q <= 1'b0;
            en_count_q   <= '0;
        end else begin
            run_meta_q   <= run_meta_d;
            run_sync_q   <= run_sync_d;
            step_meta_q  <= step_meta_d;
            step_sync_q  <= step_sync_d;
            db_level_q   <= db_level_d;
            db_prev_q    <= db_prev_d;
            db_cnt_q     <= db_cnt_d;
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            cpu_en_q     <= cpu_en_d;
            cpu_halted_q <= cpu_halted_d;
            en_count_q   <= en_count_d;
        end
    end

    assign cpu_en     = cpu_en_q;
    assign running    = (state_q == ST_RUN);
    assign cpu_halted = cpu_halted_q;
    assign en_count   = en_count_q;

endmodule

// File: tb/tb_cpu_clock_controller.sv
// tb/tb_cpu_clock_controller.sv - self-checking bench for cpu_clock_controller
module tb_cpu_clock_controller;

    localparam int T_DIV0 = 3;
    localparam int T_DIV1 = 9;
    localparam int T_DIV2 = 2;
    localparam int T_DIV3 = 0;
    localparam int T_DB   = 4;

    localparam int MODE_HALT = 0;
    localparam int MODE_RUN  = 1;
    localparam int MODE_STEP = 2;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        run_sw = 1'b0;
    logic        step_btn = 1'b0;
    logic [1:0]  div_sel = 2'd0;
    logic        halt_req = 1'b0;
    logic        cpu_en;
    logic        running;
    logic        cpu_halted;
    logic [15:0] en_count;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    cpu_clock_controller #(
        .DIV0     (32'(T_DIV0)),
        .DIV1     (32'(T_DIV1)),
        .DIV2     (32'(T_DIV2)),
        .DIV3     (32'(T_DIV3)),
        .DB_CYCLES(T_DB)
    ) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .run_sw    (run_sw),
        .step_btn  (step_btn),
        .div_sel   (div_sel),
        .halt_req  (halt_req),
        .cpu_en    (cpu_en),
        .running   (running),
        .cpu_halted(cpu_halted),
        .en_count  (en_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: input histories, a mismatch run-length for the button,
    // an integer mode and a free integer pulse tally.
    int          m_mode = MODE_HALT;
    bit          m_run_h0 = 0, m_run_h1 = 0;
    bit          m_stp_h0 = 0, m_stp_h1 = 0;
    bit          m_level = 0;
    int          m_mis = 0;
    bit          m_rise = 0;
    longint      m_cnt = 0;
    bit          m_en = 0;
    bit          m_halted = 0;
    int          m_count = 0;

    function automatic longint tc_of(input logic [1:0] s);
        case (s)
            2'd0:    return T_DIV0;
            2'd1:    return T_DIV1;
            2'd2:    return T_DIV2;
            default: return T_DIV3;
        endcase
    endfunction

    always @(posedge clk or negedge clr_n) begin : model
        bit     run_s;
        bit     ev;
        bit     fire;
        longint tc;
        if (!clr_n) begin
            m_mode = MODE_HALT;
            m_run_h0 = 0; m_run_h1 = 0; m_stp_h0 = 0; m_stp_h1 = 0;
            m_level = 0; m_mis = 0; m_rise = 0;
            m_cnt = 0; m_en = 0; m_halted = 0; m_count = 0;
        end else begin
            run_s = m_run_h1;
            ev    = m_rise;
            fire  = 0;
            tc    = tc_of(div_sel);
            if (m_mode == MODE_STEP) begin
                fire   = 1;
                m_mode = MODE_HALT;
            end else if (m_mode == MODE_RUN) begin
                if (halt_req) begin
                    m_mode = MODE_HALT; m_halted = 1; m_cnt = 0;
                end else if (!run_s) begin
                    m_mode = MODE_HALT; m_cnt = 0;
                end else if (m_cnt >= tc) begin
                    fire = 1; m_cnt = 0;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end else begin
                if (run_s && !m_halted) begin
                    m_mode = MODE_RUN; m_cnt = 0;
                end else if (ev && !run_s) begin
                    m_mode = MODE_STEP;
                end
                if (!run_s) m_halted = 0;
            end
            m_en = fire;
            if (fire) m_count = (m_count + 1) % 65536;
            m_rise = 0;
            if (m_stp_h1 != m_level) begin
                m_mis = m_mis + 1;
                if (m_mis == T_DB) begin
                    m_level = m_stp_h1;
                    m_mis   = 0;
                    m_rise  = m_level;
                end
            end else begin
                m_mis = 0;
            end
            m_run_h1 = m_run_h0; m_run_h0 = run_sw;
            m_stp_h1 = m_stp_h0; m_stp_h0 = step_btn;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle: all outputs against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (chk_on) begin
            check("cycle_outputs",
                  {13'd0, cpu_en, running, cpu_halted, en_count},
                  {13'd0, m_en, (m_mode == MODE_RUN), m_halted, m_count[15:0]});
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr_n = 1'b0; run_sw = 1'b0; step_btn = 1'b0; div_sel = 2'd0; halt_req = 1'b0;
        step(2);
        clr_n = 1'b1;
        step(1);
    endtask

    task automatic bouncy_press();
        for (int i = 0; i < 10; i++) begin
            step_btn = ((i % 4) < 2);
            step(1);
        end
        step_btn = 1'b1;
        step(20);
        step_btn = 1'b0;
        step(20);
    endtask

    initial begin
        do_reset();
        chk_on = 1'b1;
        check("reset_outputs", {cpu_en, running, cpu_halted, en_count}, 19'd0);

        // Run at TC=3: running at edge 3, pulses at edges 7, 11, 15.
        run_sw = 1'b1;
        step(3);
        check("run_running_e3", running, 1);
        step(3);
        check("run_no_en_e6", cpu_en, 0);
        step(1);
        check("run_en_e7", cpu_en, 1);
        step(8);
        check("run_en_e15", cpu_en, 1);
        check("run_count_e15", en_count, 3);

        // Reset mid-run clears everything immediately.
        step(2);
        clr_n = 1'b0;
        #1;
        check("mid_run_reset", {cpu_en, running, cpu_halted, en_count}, 19'd0);
        step(2);
        clr_n = 1'b1;
        step(2);
        check("post_reset_no_run", {cpu_en, running}, 2'b00);
        step(10);

        // Rate change: TC=9, switch to TC=0 with cnt=5.
        do_reset();
        div_sel = 2'd1;
        run_sw  = 1'b1;
        step(8);
        check("rate_no_en_yet", en_count, 0);
        div_sel = 2'd3;
        step(1);
        check("rate_first_en", {cpu_en, en_count}, {1'b1, 16'd1});
        step(3);
        check("rate_every_cycle", {cpu_en, en_count}, {1'b1, 16'd4});

        // CPU halt on the terminal-count cycle.
        do_reset();
        run_sw = 1'b1;
        step(10);
        halt_req = 1'b1;
        step(1);
        halt_req = 1'b0;
        check("halt_state", {cpu_en, running, cpu_halted, en_count}, {3'b001, 16'd1});
        step(10);
        check("halt_sticky", {running, cpu_halted}, 2'b01);
        run_sw = 1'b0;
        step(4);
        check("halt_rearm", cpu_halted, 0);
        run_sw = 1'b1;
        step(3);
        check("halt_resume", running, 1);
        run_sw = 1'b0;
        step(5);

        // Clean step press: pulse lands just after edge 4+DB.
        do_reset();
        step_btn = 1'b1;
        step(7);
        check("step_no_en_e7", {cpu_en, running}, 2'b00);
        step(1);
        check("step_en_e8", {cpu_en, en_count}, {1'b1, 16'd1});
        step(1);
        check("step_single", cpu_en, 0);
        step_btn = 1'b0;
        step(20);

        // Bouncy presses: one pulse per press.
        bouncy_press();
        check("bounce_one", en_count, 2);
        bouncy_press();
        check("bounce_two", en_count, 3);

        // Step while running is ignored.
        run_sw = 1'b1;
        step(6);
        bouncy_press();
        run_sw = 1'b0;
        step(6);

        // Wrap of the pulse counter at TC=0.
        do_reset();
        div_sel = 2'd3;
        run_sw  = 1'b1;
        step(3);
        check("wrap_start", {running, en_count}, {1'b1, 16'd0});
        step(65535);
        check("wrap_ffff", en_count, 16'hFFFF);
        step(1);
        check("wrap_zero", {cpu_en, en_count}, {1'b1, 16'd0});

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
